// File: rtl/mccu_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
// master = control unit (mccu), slave = datapath.
interface mccu_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       z;
   logic       mem_rdy;

   logic       wpc;
   logic       wir;
   logic       wmem;
   logic       wreg;
   logic       iord;
   logic       regrt;
   logic       m2reg;
   logic       jal;
   logic       shift;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic       sext;
   logic [3:0] aluc;
   logic [1:0] pcsrc;
   logic       ill;
   logic [2:0] state;

   modport master (
      input  op, func, z, mem_rdy,
      output wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift,
             alusrca, alusrcb, sext, aluc, pcsrc, ill, state
   );

   modport slave (
      output op, func, z, mem_rdy,
      input  wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, shift,
             alusrca, alusrcb, sext, aluc, pcsrc, ill, state
   );
endinterface

// File: rtl/mccu.sv
// Multicycle MIPS32 control unit sequencing IF/ID/EXE/MEM/WB over a shared-memory datapath.
// Optional feature: define MCCU_PERF_EN to add cycle and retired-instruction counters.
module mccu #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             clrn,
   mccu_if.master           bus
`ifdef MCCU_PERF_EN
   ,
   output logic [CNT_W-1:0] cyc_cnt,
   output logic [CNT_W-1:0] ins_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      C_ILL,
      C_RALU,
      C_RSHIFT,
      C_JR,
      C_IALU,
      C_LW,
      C_SW,
      C_BEQ,
      C_BNE,
      C_J,
      C_JAL
   } iclass_t;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_LUI = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   state_t     state_q;
   state_t     state_d;

   iclass_t    dec_cls;
   logic [3:0] dec_aluc;
   logic       dec_sext;

   logic       wpc_c;
   logic       wir_c;
   logic       wmem_c;
   logic       wreg_c;
   logic       iord_c;
   logic       regrt_c;
   logic       m2reg_c;
   logic       jal_c;
   logic       shift_c;
   logic       alusrca_c;
   logic [1:0] alusrcb_c;
   logic       sext_c;
   logic [3:0] aluc_c;
   logic [1:0] pcsrc_c;
   logic       ill_c;
   logic       br_taken;

   // Instruction decode: class, ALU function and immediate extension mode.
   always_comb begin
      dec_cls  = C_ILL;
      dec_aluc = ALU_ADD;
      dec_sext = 1'b0;
      case (bus.op)
         6'h00: begin
            case (bus.func)
               6'h20: begin dec_cls = C_RALU;   dec_aluc = ALU_ADD; end
               6'h22: begin dec_cls = C_RALU;   dec_aluc = ALU_SUB; end
               6'h24: begin dec_cls = C_RALU;   dec_aluc = ALU_AND; end
               6'h25: begin dec_cls = C_RALU;   dec_aluc = ALU_OR;  end
               6'h26: begin dec_cls = C_RALU;   dec_aluc = ALU_XOR; end
               6'h00: begin dec_cls = C_RSHIFT; dec_aluc = ALU_SLL; end
               6'h02: begin dec_cls = C_RSHIFT; dec_aluc = ALU_SRL; end
               6'h03: begin dec_cls = C_RSHIFT; dec_aluc = ALU_SRA; end
               6'h08: dec_cls = C_JR;
               default: dec_cls = C_ILL;
            endcase
         end
         6'h08: begin dec_cls = C_IALU; dec_aluc = ALU_ADD; dec_sext = 1'b1; end
         6'h0C: begin dec_cls = C_IALU; dec_aluc = ALU_AND; end
         6'h0D: begin dec_cls = C_IALU; dec_aluc = ALU_OR;  end
         6'h0E: begin dec_cls = C_IALU; dec_aluc = ALU_XOR; end
         6'h0F: begin dec_cls = C_IALU; dec_aluc = ALU_LUI; end
         6'h23: begin dec_cls = C_LW;   dec_sext = 1'b1; end
         6'h2B: begin dec_cls = C_SW;   dec_sext = 1'b1; end
         6'h04: begin dec_cls = C_BEQ;  dec_aluc = ALU_SUB; end
         6'h05: begin dec_cls = C_BNE;  dec_aluc = ALU_SUB; end
         6'h02: dec_cls = C_J;
         6'h03: dec_cls = C_JAL;
         default: dec_cls = C_ILL;
      endcase
   end

   assign br_taken = ((dec_cls == C_BEQ) && bus.z) || ((dec_cls == C_BNE) && !bus.z);

   // Next state and control outputs; everything defaults to 0 and stays put.
   always_comb begin
      state_d   = state_q;
      wpc_c     = 1'b0;
      wir_c     = 1'b0;
      wmem_c    = 1'b0;
      wreg_c    = 1'b0;
      iord_c    = 1'b0;
      regrt_c   = 1'b0;
      m2reg_c   = 1'b0;
      jal_c     = 1'b0;
      shift_c   = 1'b0;
      alusrca_c = 1'b0;
      alusrcb_c = 2'b00;
      sext_c    = 1'b0;
      aluc_c    = ALU_ADD;
      pcsrc_c   = 2'b00;
      ill_c     = 1'b0;

      case (state_q)
         S_IF: begin
            alusrcb_c = 2'b01;
            wpc_c     = bus.mem_rdy;
            wir_c     = bus.mem_rdy;
            if (bus.mem_rdy) state_d = S_ID;
         end

         S_ID: begin
            alusrcb_c = 2'b11;
            state_d   = S_EXE;
            case (dec_cls)
               C_J: begin
                  wpc_c   = 1'b1;
                  pcsrc_c = 2'b11;
                  state_d = S_IF;
               end
               C_JAL: begin
                  wpc_c   = 1'b1;
                  pcsrc_c = 2'b11;
                  wreg_c  = 1'b1;
                  jal_c   = 1'b1;
                  state_d = S_IF;
               end
               C_JR: begin
                  wpc_c   = 1'b1;
                  pcsrc_c = 2'b10;
                  state_d = S_IF;
               end
               C_ILL: begin
                  ill_c   = 1'b1;
                  state_d = S_IF;
               end
               default: state_d = S_EXE;
            endcase
         end

         S_EXE: begin
            alusrca_c = 1'b1;
            aluc_c    = dec_aluc;
            case (dec_cls)
               C_BEQ, C_BNE: begin
                  aluc_c  = ALU_SUB;
                  wpc_c   = br_taken;
                  pcsrc_c = br_taken ? 2'b01 : 2'b00;
                  state_d = S_IF;
               end
               C_LW, C_SW: begin
                  alusrcb_c = 2'b10;
                  sext_c    = 1'b1;
                  aluc_c    = ALU_ADD;
                  state_d   = S_MEM;
               end
               C_RALU: state_d = S_WB;
               C_RSHIFT: begin
                  shift_c = 1'b1;
                  state_d = S_WB;
               end
               C_IALU: begin
                  alusrcb_c = 2'b10;
                  sext_c    = dec_sext;
                  state_d   = S_WB;
               end
               default: state_d = S_IF;
            endcase
         end

         // A store holds its strobe until the memory accepts it.
         S_MEM: begin
            iord_c = 1'b1;
            if (dec_cls == C_SW) begin
               wmem_c = 1'b1;
               if (bus.mem_rdy) state_d = S_IF;
            end else if (bus.mem_rdy) begin
               state_d = S_WB;
            end
         end

         S_WB: begin
            wreg_c  = 1'b1;
            regrt_c = (dec_cls != C_RALU) && (dec_cls != C_RSHIFT);
            m2reg_c = (dec_cls == C_LW);
            state_d = S_IF;
         end

         default: state_d = S_IF;
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_q <= S_IF;
      else       state_q <= state_d;
   end

   // Write enables and ill are masked directly by reset so nothing leaks while it is held.
   assign bus.wpc     = wpc_c  & clrn;
   assign bus.wir     = wir_c  & clrn;
   assign bus.wmem    = wmem_c & clrn;
   assign bus.wreg    = wreg_c & clrn;
   assign bus.ill     = ill_c  & clrn;
   assign bus.iord    = iord_c;
   assign bus.regrt   = regrt_c;
   assign bus.m2reg   = m2reg_c;
   assign bus.jal     = jal_c;
   assign bus.shift   = shift_c;
   assign bus.alusrca = alusrca_c;
   assign bus.alusrcb = alusrcb_c;
   assign bus.sext    = sext_c;
   assign bus.aluc    = aluc_c;
   assign bus.pcsrc   = pcsrc_c;
   assign bus.state   = state_q;

`ifdef MCCU_PERF_EN
   logic [CNT_W-1:0] cyc_cnt_q;
   logic [CNT_W-1:0] cyc_cnt_d;
   logic [CNT_W-1:0] ins_cnt_q;
   logic [CNT_W-1:0] ins_cnt_d;

   // An instruction retires whenever the sequencer re-enters IF from elsewhere.
   always_comb begin
      cyc_cnt_d = cyc_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      ins_cnt_d = ins_cnt_q;
      if ((state_d == S_IF) && (state_q != S_IF))
         ins_cnt_d = ins_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cyc_cnt_q <= '0;
         ins_cnt_q <= '0;
      end else begin
         cyc_cnt_q <= cyc_cnt_d;
         ins_cnt_q <= ins_cnt_d;
      end
   end

   assign cyc_cnt = cyc_cnt_q;
   assign ins_cnt = ins_cnt_q;
`endif

endmodule

// File: tb/tb_mccu.sv
// Self-checking bench for mccu: per-cycle control vectors compared against a
// table-driven instruction model that expands each instruction into its expected cycle trace.
module tb_mccu;

   logic clk  = 1'b0;
   logic clrn = 1'b0;

   mccu_if bus ();

`ifdef MCCU_PERF_EN
   logic [31:0] cycCnt;
   logic [31:0] insCnt;
   mccu #(.CNT_W(32)) dut (
      .clk     (clk),
      .clrn    (clrn),
      .bus     (bus.master),
      .cyc_cnt (cycCnt),
      .ins_cnt (insCnt)
   );
`else
   mccu #(.CNT_W(32)) dut (
      .clk  (clk),
      .clrn (clrn),
      .bus  (bus.master)
   );
`endif

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] st;
      logic       wpc;
      logic       wir;
      logic       wmem;
      logic       wreg;
      logic       iord;
      logic       regrt;
      logic       m2reg;
      logic       jal;
      logic       shift;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       sext;
      logic [3:0] aluc;
      logic [1:0] pcsrc;
      logic       ill;
   } ctrl_t;

   typedef struct {
      logic [5:0] op;
      logic [5:0] func;
      logic       z;
      logic       rdy;
      ctrl_t      exp;
   } cyc_t;

   typedef enum int {K_ILL, K_J, K_JAL, K_JR, K_BEQ, K_BNE, K_R, K_SH, K_I, K_LW, K_SW} kind_t;

   // Supported instruction table: opcode, function (R-type only), kind, ALU code, sign-extend.
   localparam int NINS = 20;
   logic [5:0] insOp   [NINS] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                  6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
   logic [5:0] insFunc [NINS] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08,
                                  6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
   kind_t      insKind [NINS] = '{K_R, K_R, K_R, K_R, K_R, K_SH, K_SH, K_SH, K_JR,
                                  K_I, K_I, K_I, K_I, K_I, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL};
   logic [3:0] insAlu  [NINS] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hF, 4'h0,
                                  4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0};
   logic       insSext [NINS] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   cyc_t trace[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   function automatic ctrl_t observedCtrl();
      ctrl_t c;
      c.st      = bus.state;
      c.wpc     = bus.wpc;
      c.wir     = bus.wir;
      c.wmem    = bus.wmem;
      c.wreg    = bus.wreg;
      c.iord    = bus.iord;
      c.regrt   = bus.regrt;
      c.m2reg   = bus.m2reg;
      c.jal     = bus.jal;
      c.shift   = bus.shift;
      c.alusrca = bus.alusrca;
      c.alusrcb = bus.alusrcb;
      c.sext    = bus.sext;
      c.aluc    = bus.aluc;
      c.pcsrc   = bus.pcsrc;
      c.ill     = bus.ill;
      return c;
   endfunction

   // Fetch-phase controls: PC+4 through the ALU, writes follow memory readiness.
   function automatic ctrl_t fetchCtrl(input logic rdy);
      ctrl_t c = '0;
      c.alusrcb = 2'b01;
      c.wpc     = rdy;
      c.wir     = rdy;
      return c;
   endfunction

   task automatic pushCycle(input logic [5:0] op, input logic [5:0] func, input logic z,
                            input logic rdy, input ctrl_t exp);
      cyc_t e;
      e.op = op; e.func = func; e.z = z; e.rdy = rdy; e.exp = exp;
      trace.push_back(e);
   endtask

   // Expand one instruction into the cycle-by-cycle inputs and expected controls.
   task automatic buildTrace(input logic [5:0] op, input logic [5:0] func, input logic z,
                             input int ifWait, input int memWait);
      kind_t      k   = K_ILL;
      logic [3:0] alu = 4'h0;
      logic       sx  = 1'b0;
      ctrl_t      c;
      logic       taken;
      for (int i = 0; i < NINS; i++)
         if (op == insOp[i] && (op != 6'h00 || func == insFunc[i])) begin
            k = insKind[i]; alu = insAlu[i]; sx = insSext[i];
         end

      for (int i = 0; i <= ifWait; i++)
         pushCycle(6'($urandom), 6'($urandom), 1'($urandom), (i == ifWait), fetchCtrl(i == ifWait));

      c = '0; c.st = 3'd1; c.alusrcb = 2'b11;
      case (k)
         K_J:   begin c.wpc = 1; c.pcsrc = 2'b11; end
         K_JAL: begin c.wpc = 1; c.pcsrc = 2'b11; c.wreg = 1; c.jal = 1; end
         K_JR:  begin c.wpc = 1; c.pcsrc = 2'b10; end
         K_ILL: c.ill = 1;
         default: ;
      endcase
      pushCycle(op, func, 1'($urandom), 1'($urandom), c);
      if (k inside {K_J, K_JAL, K_JR, K_ILL}) return;

      c = '0; c.st = 3'd2; c.alusrca = 1;
      case (k)
         K_BEQ, K_BNE: begin
            taken   = (k == K_BEQ) ? z : !z;
            c.aluc  = 4'b0001;
            c.wpc   = taken;
            c.pcsrc = taken ? 2'b01 : 2'b00;
         end
         K_R:  c.aluc = alu;
         K_SH: begin c.aluc = alu; c.shift = 1; end
         K_I:  begin c.aluc = alu; c.alusrcb = 2'b10; c.sext = sx; end
         default: begin c.aluc = 4'b0000; c.alusrcb = 2'b10; c.sext = 1; end
      endcase
      pushCycle(op, func, (k inside {K_BEQ, K_BNE}) ? z : 1'($urandom), 1'($urandom), c);
      if (k inside {K_BEQ, K_BNE}) return;

      if (k inside {K_LW, K_SW})
         for (int i = 0; i <= memWait; i++) begin
            c = '0; c.st = 3'd3; c.iord = 1; c.wmem = (k == K_SW);
            pushCycle(op, func, 1'($urandom), (i == memWait), c);
         end
      if (k == K_SW) return;

      c = '0; c.st = 3'd4; c.wreg = 1; c.regrt = (k != K_R && k != K_SH); c.m2reg = (k == K_LW);
      pushCycle(op, func, 1'($urandom), 1'($urandom), c);
   endtask

   task automatic applyStimulus(input string name);
      int n = trace.size();
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         clrn        = 1'b1;
         bus.op      = trace[i].op;
         bus.func    = trace[i].func;
         bus.z       = trace[i].z;
         bus.mem_rdy = trace[i].rdy;
         @(negedge clk);
         checkOutput($sformatf("%s_c%0d", name, i), 32'(observedCtrl()), 32'(trace[i].exp));
      end
      trace.delete();
   endtask

   // Assert reset asynchronously and confirm IF with every write held off.
   task automatic resetCheck(input string name);
      ctrl_t r = fetchCtrl(1'b0);
      #2;
      clrn        = 1'b0;
      bus.mem_rdy = 1'b1;
      #1;
      checkOutput({name, "_async"}, 32'(observedCtrl()), 32'(r));
      @(posedge clk);
      #1;
      bus.op = 6'h3F;
      @(negedge clk);
      checkOutput({name, "_held"}, 32'(observedCtrl()), 32'(r));
   endtask

   initial begin
      int idx;
      logic [5:0] op;
      logic [5:0] func;
      bus.op = 6'h00; bus.func = 6'h20; bus.z = 1'b0; bus.mem_rdy = 1'b1;

      @(negedge clk);
      checkOutput("reset_state", 32'(observedCtrl()), 32'(fetchCtrl(1'b0)));
      resetCheck("reset_init");

      buildTrace(6'h00, 6'h20, 1'b0, 0, 0); applyStimulus("add");
      buildTrace(6'h23, 6'h00, 1'b0, 0, 2); applyStimulus("lw_wait2");
      buildTrace(6'h2B, 6'h00, 1'b0, 0, 1); applyStimulus("sw_wait1");
      buildTrace(6'h04, 6'h00, 1'b1, 0, 0); applyStimulus("beq_taken");
      buildTrace(6'h05, 6'h00, 1'b1, 0, 0); applyStimulus("bne_nottaken");
      buildTrace(6'h03, 6'h00, 1'b0, 1, 0); applyStimulus("jal");
      buildTrace(6'h3F, 6'h00, 1'b0, 0, 0); applyStimulus("illegal");

      buildTrace(6'h00, 6'h20, 1'b0, 0, 0);
      while (trace.size() > 3) void'(trace.pop_back());
      applyStimulus("add_cut");
      resetCheck("reset_exe");

      for (int n = 0; n < 200; n++) begin
         idx = $urandom_range(0, NINS + 2);
         if (idx < NINS) begin
            op   = insOp[idx];
            func = (op == 6'h00) ? insFunc[idx] : 6'($urandom);
         end else if (idx == NINS) begin
            op = 6'h3F; func = 6'($urandom);
         end else if (idx == NINS + 1) begin
            op = 6'h00; func = 6'h21;
         end else begin
            op = 6'h01; func = 6'($urandom);
         end
         buildTrace(op, func, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
         applyStimulus($sformatf("rnd%0d_op%h_f%h", n, op, func));
      end

      buildTrace(6'h00, 6'h22, 1'b0, 0, 0); applyStimulus("final_sub");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
